// File: rtl/scan_pkg.sv
// rtl/scan_pkg.sv - shared widths, move codes, state encoding and helpers for the scan move sequencer
package scan_pkg;

    localparam int MOVE_W    = 4;
    localparam int MAX_MOVES = 24;
    localparam int NUM_STEPS = 49;
    localparam int STEP_W    = 6;
    localparam int LEN_W     = 5;
    localparam int SEQ_W     = MAX_MOVES * MOVE_W;

    typedef enum logic [MOVE_W-1:0] {
        MV_NONE = 4'd0,
        MV_R    = 4'd2,
        MV_RI   = 4'd3,
        MV_U    = 4'd4,
        MV_UI   = 4'd5,
        MV_F    = 4'd6,
        MV_FI   = 4'd7,
        MV_L    = 4'd8,
        MV_LI   = 4'd9,
        MV_B    = 4'd10,
        MV_BI   = 4'd11,
        MV_D    = 4'd12,
        MV_DI   = 4'd13
    } move_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_STREAM,
        ST_DONE
    } scan_state_e;

    typedef struct packed {
        logic [LEN_W-1:0] len;
        logic [SEQ_W-1:0] seq;
    } rom_entry_t;

    // Sequences are right-justified with the first move in the highest occupied slot.
    function automatic logic [MOVE_W-1:0] pick_move(input logic [SEQ_W-1:0] seq,
                                                    input logic [LEN_W-1:0] len,
                                                    input logic [LEN_W-1:0] k);
        logic [SEQ_W-1:0] w_sh;
        w_sh = seq >> ((int'(len) - int'(k) - 1) * MOVE_W);
        return w_sh[MOVE_W-1:0];
    endfunction

endpackage

// File: rtl/scan_move_rom.sv
// rtl/scan_move_rom.sv - synchronous-read table of per-step setup move sequences
module scan_move_rom
    import scan_pkg::*;
(
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_rd_en,
    input  logic [STEP_W-1:0] i_step,
    output logic [LEN_W-1:0]  o_len,
    output logic [SEQ_W-1:0]  o_seq
);

    function automatic rom_entry_t mk(input int n, input logic [SEQ_W-1:0] s);
        rom_entry_t e;
        e.len = LEN_W'(n);
        e.seq = s;
        return e;
    endfunction

    function automatic rom_entry_t rom_lookup(input int s);
        case (s)
            0:  return mk(5,  96'h83745);
            1:  return mk(3,  96'h623);
            2:  return mk(2,  96'h42);
            3:  return mk(3,  96'h29c);
            4:  return mk(2,  96'h6d);
            5:  return mk(4,  96'h6c27);
            6:  return mk(1,  96'h8);
            7:  return mk(3,  96'ha4b);
            8:  return mk(4,  96'h2453);
            9:  return mk(2,  96'h93);
            10: return mk(3,  96'h7b6);
            11: return mk(5,  96'h4c5d2);
            12: return mk(2,  96'hb8);
            13: return mk(3,  96'h263);
            14: return mk(4,  96'h9d4c);
            15: return mk(1,  96'h5);
            16: return mk(3,  96'ha2b);
            17: return mk(2,  96'h7c);
            18: return mk(4,  96'h3948);
            19: return mk(3,  96'hd6c);
            20: return mk(5,  96'h24b5a);
            21: return mk(2,  96'h68);
            22: return mk(3,  96'h59c);
            23: return mk(1,  96'hd);
            24: return mk(4,  96'h8a2b);
            25: return mk(3,  96'h47b);
            26: return mk(2,  96'hc3);
            27: return mk(5,  96'h6a7b2);
            28: return mk(3,  96'h935);
            29: return mk(4,  96'hd48c);
            30: return mk(2,  96'h2a);
            31: return mk(3,  96'hb7c);
            32: return mk(6,  96'h246835);
            33: return mk(2,  96'h9d);
            34: return mk(4,  96'h5c6a);
            35: return mk(3,  96'h283);
            36: return mk(1,  96'hb);
            37: return mk(4,  96'h7d9c);
            38: return mk(3,  96'h6a4);
            39: return mk(2,  96'h58);
            40: return mk(5,  96'hc2d37);
            41: return mk(3,  96'ha4b);
            42: return mk(4,  96'h2935);
            43: return mk(2,  96'h7c);
            44: return mk(3,  96'hd4c);
            45: return mk(6,  96'h8a6b42);
            46: return mk(2,  96'h35);
            47: return mk(0,  96'h0);
            // Solve-return: undo all accumulated setup moves.
            48: return mk(24, 96'h2468acd35792b4d6c8a3579b);
            default: return mk(0, 96'h0);
        endcase
    endfunction

    for (genvar i = 0; i < NUM_STEPS; i++) begin : g_len_check
        localparam rom_entry_t E = rom_lookup(i);
        if (int'(E.len) > MAX_MOVES) begin : g_too_long
            $fatal(1, "scan_move_rom: entry longer than MAX_MOVES");
        end
    end

    rom_entry_t w_entry;

    always_comb begin
        w_entry = rom_lookup(int'(i_step));
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_len <= '0;
            o_seq <= '0;
        end else if (i_rd_en) begin
            o_len <= w_entry.len;
            o_seq <= w_entry.seq;
        end
    end

endmodule

// File: rtl/scan_move_sequencer.sv
// rtl/scan_move_sequencer.sv - fetches a scan step's move list and emits it packed and as a move stream
module scan_move_sequencer
    import scan_pkg::*;
#(
    parameter int MOVE_W    = scan_pkg::MOVE_W,
    parameter int MAX_MOVES = scan_pkg::MAX_MOVES,
    parameter int NUM_STEPS = scan_pkg::NUM_STEPS,
    parameter int STEP_W    = scan_pkg::STEP_W,
    parameter int LEN_W     = scan_pkg::LEN_W
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic [STEP_W-1:0]             step,
    input  logic                          abort,
    input  logic                          move_ready,
    output logic [MOVE_W-1:0]             move_out,
    output logic                          move_valid,
    output logic                          last_move,
    output logic [MAX_MOVES*MOVE_W-1:0]   moves,
    output logic [LEN_W-1:0]              moves_len,
    output logic                          new_moves,
    output logic                          busy,
    output logic                          done,
    output logic                          err
);

    // The ROM table is fixed to the package geometry.
    if (MOVE_W != scan_pkg::MOVE_W || MAX_MOVES != scan_pkg::MAX_MOVES ||
        NUM_STEPS != scan_pkg::NUM_STEPS || STEP_W != scan_pkg::STEP_W ||
        LEN_W != scan_pkg::LEN_W) begin : g_param_mismatch
        $fatal(1, "scan_move_sequencer: parameters differ from scan_pkg");
    end

    scan_state_e          r_state;
    logic [LEN_W-1:0]     r_idx;
    logic [LEN_W-1:0]     w_next_idx;
    logic                 w_in_range;
    logic                 w_accept;
    logic [LEN_W-1:0]     w_rom_len;
    logic [SEQ_W-1:0]     w_rom_seq;

    assign w_in_range = (step < STEP_W'(NUM_STEPS));
    assign w_accept   = (r_state == ST_IDLE) && start && !abort && w_in_range;
    assign w_next_idx = r_idx + LEN_W'(1);

    scan_move_rom u_rom (
        .i_clock (clock),
        .i_reset (reset),
        .i_rd_en (w_accept),
        .i_step  (step),
        .o_len   (w_rom_len),
        .o_seq   (w_rom_seq)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            move_out   <= '0;
            move_valid <= 1'b0;
            last_move  <= 1'b0;
            moves      <= '0;
            moves_len  <= '0;
            new_moves  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            new_moves <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        if (w_in_range) begin
                            r_state <= ST_FETCH;
                            busy    <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                ST_FETCH: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                        busy    <= 1'b0;
                    end else begin
                        moves     <= w_rom_seq;
                        moves_len <= w_rom_len;
                        new_moves <= 1'b1;
                        r_idx     <= '0;
                        if (w_rom_len != '0) begin
                            r_state    <= ST_STREAM;
                            move_valid <= 1'b1;
                            move_out   <= pick_move(w_rom_seq, w_rom_len, '0);
                            last_move  <= (w_rom_len == LEN_W'(1));
                        end else begin
                            r_state <= ST_DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end
                    end
                end
                ST_STREAM: begin
                    if (abort) begin
                        r_state    <= ST_IDLE;
                        busy       <= 1'b0;
                        move_valid <= 1'b0;
                        last_move  <= 1'b0;
                        move_out   <= '0;
                    end else if (move_ready) begin
                        if (last_move) begin
                            r_state    <= ST_DONE;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                            move_valid <= 1'b0;
                            last_move  <= 1'b0;
                            move_out   <= '0;
                        end else begin
                            r_idx     <= w_next_idx;
                            move_out  <= pick_move(moves, moves_len, w_next_idx);
                            last_move <= (w_next_idx == moves_len - LEN_W'(1));
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scan_move_sequencer.sv
// tb/tb_scan_move_sequencer.sv - directed scoreboard bench for scan_move_sequencer
module tb_scan_move_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [5:0]  step;
    logic        abort;
    logic        move_ready;
    logic [3:0]  move_out;
    logic        move_valid;
    logic        last_move;
    logic [95:0] moves;
    logic [4:0]  moves_len;
    logic        new_moves;
    logic        busy;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;
    logic [3:0] exp_q[$];

    localparam logic [95:0] SEQ0  = 96'h83745;
    localparam logic [95:0] SEQ1  = 96'h623;
    localparam logic [95:0] SEQ48 = 96'h2468acd35792b4d6c8a3579b;

    scan_move_sequencer dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .step       (step),
        .abort      (abort),
        .move_ready (move_ready),
        .move_out   (move_out),
        .move_valid (move_valid),
        .last_move  (last_move),
        .moves      (moves),
        .moves_len  (moves_len),
        .new_moves  (new_moves),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_move_out"},   move_out,   0);
        check({tag, "_move_valid"}, move_valid, 0);
        check({tag, "_last_move"},  last_move,  0);
        check({tag, "_moves"},      moves,      0);
        check({tag, "_moves_len"},  moves_len,  0);
        check({tag, "_new_moves"},  new_moves,  0);
        check({tag, "_busy"},       busy,       0);
        check({tag, "_done"},       done,       0);
        check({tag, "_err"},        err,        0);
    endtask

    task automatic push_seq(input logic [95:0] v, input int n);
        for (int k = n - 1; k >= 0; k--) begin
            exp_q.push_back(v[k*4 +: 4]);
        end
    endtask

    // Drives start and checks the FETCH cycle and the t+2 load; returns at t+2.
    task automatic step_begin(input logic [5:0] stp, input logic [95:0] v, input int n);
        push_seq(v, n);
        start = 1'b1;
        step  = stp;
        tick();
        start = 1'b0;
        check("fetch_busy", busy, 1);
        check("fetch_no_new", new_moves, 0);
        check("fetch_no_err", err, 0);
        tick();
        check("load_new_moves", new_moves, 1);
        check("load_len", moves_len, n);
        check("load_moves", moves, v);
    endtask

    task automatic stream_step(input int mode, input bit inject, input logic [95:0] v);
        int cyc = 0;
        logic [3:0] held = '0;
        bit have_held = 1'b0;
        while (exp_q.size() > 0 && cyc < 200) begin
            move_ready = (mode == 0) ? 1'b1 : cyc[0];
            if (inject) begin
                start = (cyc == 1);
                step  = 6'd5;
            end
            check("stream_valid", move_valid, 1);
            if (cyc > 0) check("new_moves_once", new_moves, 0);
            check("last_move", last_move, exp_q.size() == 1);
            if (have_held) check("hold_stable", move_out, held);
            if (move_valid && move_ready) begin
                check("move_code", move_out, exp_q.pop_front());
                have_held = 1'b0;
            end else begin
                held      = move_out;
                have_held = 1'b1;
            end
            tick();
            cyc++;
        end
        start      = 1'b0;
        move_ready = 1'b0;
        if (cyc >= 200) begin
            n_checks++;
            n_fail++;
            $error("FAIL stream_timeout observed=%0d remaining expected=0", exp_q.size());
            exp_q.delete();
        end
        check("done_pulse", done, 1);
        check("valid_after_last", move_valid, 0);
        check("busy_in_done", busy, 0);
        check("moves_hold", moves, v);
        tick();
        check("done_cleared", done, 0);
        check("busy_idle", busy, 0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; step = '0; abort = 1'b0; move_ready = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();

        // Step 0, always ready
        step_begin(6'd0, SEQ0, 5);
        stream_step(0, 1'b0, SEQ0);

        // Step 1 with toggling backpressure
        step_begin(6'd1, SEQ1, 3);
        stream_step(1, 1'b0, SEQ1);

        // Out-of-range step
        start = 1'b1; step = 6'd49;
        tick();
        start = 1'b0;
        check("err_pulse", err, 1);
        check("err_busy", busy, 0);
        check("err_moves_kept", moves, SEQ1);
        tick();
        check("err_cleared", err, 0);
        check("err_busy_after", busy, 0);
        check("err_no_new", new_moves, 0);

        // Abort after two handshakes of step 0
        step_begin(6'd0, SEQ0, 5);
        move_ready = 1'b1;
        tick();
        tick();
        check("abort_pre_valid", move_valid, 1);
        check("abort_pre_code", move_out, 4'd7);
        abort = 1'b1; move_ready = 1'b0;
        tick();
        abort = 1'b0;
        check("abort_valid", move_valid, 0);
        check("abort_no_done", done, 0);
        check("abort_busy", busy, 0);
        check("abort_moves", moves, SEQ0);
        tick();
        check("abort_no_done_later", done, 0);
        exp_q.delete();
        step_begin(6'd1, SEQ1, 3);
        stream_step(0, 1'b0, SEQ1);

        // Start while busy is ignored
        step_begin(6'd0, SEQ0, 5);
        stream_step(0, 1'b1, SEQ0);
        check("busy_start_len", moves_len, 5);

        // Zero-length step goes straight to DONE
        start = 1'b1; step = 6'd47;
        tick();
        start = 1'b0;
        check("len0_busy", busy, 1);
        tick();
        check("len0_new", new_moves, 1);
        check("len0_len", moves_len, 0);
        check("len0_moves", moves, 0);
        check("len0_done", done, 1);
        check("len0_valid", move_valid, 0);
        check("len0_busy_done", busy, 0);
        tick();
        check("len0_done_clr", done, 0);
        check("len0_valid_after", move_valid, 0);

        // Maximum-length step
        step_begin(6'd48, SEQ48, 24);
        stream_step(0, 1'b0, SEQ48);

        // Abort and start in the same IDLE cycle
        abort = 1'b1; start = 1'b1; step = 6'd1;
        tick();
        abort = 1'b0; start = 1'b0;
        check("abort_start_busy", busy, 0);
        check("abort_start_err", err, 0);
        tick();
        check("abort_start_new", new_moves, 0);
        check("abort_start_valid", move_valid, 0);

        // Reset mid-stream
        step_begin(6'd1, SEQ1, 3);
        move_ready = 1'b0;
        tick();
        check("pre_reset_valid", move_valid, 1);
        reset = 1'b1;
        tick();
        check_all_zero("reset_mid");
        reset = 1'b0;
        exp_q.delete();
        tick();
        check("post_reset_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
